// File: rtl/module_display_scan.sv
// Two-digit multiplexed 7-segment scanner: digit 0 shows the data pattern,
// digit 1 shows the error status, with dark gaps between digits and blinking on double error.
module module_display_scan #(
    parameter int SCAN_DIV    = 27000,
    parameter int DEAD_CYCLES = 270,
    parameter int BLINK_DIV   = 6750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] salida_mux,
    input  logic       error_simple,
    input  logic       error_doble,
    input  logic       no_error,
    output logic [1:0] anodo,
    output logic [6:0] segmentos
);

    localparam int SCAN_MAX = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int CNT_W    = (SCAN_MAX > 1) ? $clog2(SCAN_MAX) : 1;
    localparam int BLINK_W  = $clog2(BLINK_DIV);

    localparam logic [CNT_W-1:0]   SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [6:0] PAT_TWO   = 7'b1011011;
    localparam logic [6:0] PAT_ONE   = 7'b0000110;
    localparam logic [6:0] PAT_ZERO  = 7'b0111111;
    localparam logic [6:0] PAT_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DARK  = 7'h7F;
    localparam logic [1:0] AN_DARK   = 2'b11;

    typedef enum logic [1:0] {
        SHOW0  = 2'd0,
        BLANK0 = 2'd1,
        SHOW1  = 2'd2,
        BLANK1 = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [6:0]           pat0_q, pat0_d;
    logic [6:0]           pat1_q, pat1_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_fase_q, blink_fase_d;
    logic [1:0]           anodo_q, anodo_d;
    logic [6:0]           seg_q, seg_d;
    logic [6:0]           status_pat;
    logic [CNT_W-1:0]     cnt_last;
    logic                 blink_dark;

    always_comb begin
        status_pat = PAT_BLANK;
        if (error_doble) begin
            status_pat = PAT_TWO;
        end else if (error_simple) begin
            status_pat = PAT_ONE;
        end else if (no_error) begin
            status_pat = PAT_ZERO;
        end
    end

    // Scan sequencer: the shared counter restarts on every state change.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        pat0_d   = pat0_q;
        pat1_d   = pat1_q;
        cnt_last = BLANK_LAST;
        if (state_q == SHOW0 || state_q == SHOW1) begin
            cnt_last = SHOW_LAST;
        end
        if (cnt_q == cnt_last) begin
            cnt_d = '0;
            case (state_q)
                SHOW0:   state_d = BLANK0;
                BLANK0:  begin
                    state_d = SHOW1;
                    pat1_d  = status_pat;
                end
                SHOW1:   state_d = BLANK1;
                BLANK1:  begin
                    state_d = SHOW0;
                    pat0_d  = salida_mux;
                end
                default: state_d = BLANK1;
            endcase
        end
    end

    always_comb begin
        blink_cnt_d  = blink_cnt_q + 1'b1;
        blink_fase_d = blink_fase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d  = '0;
            blink_fase_d = ~blink_fase_q;
        end
    end

    // Outputs are built from the next state so they register on the same edge the state moves.
    always_comb begin
        anodo_d    = AN_DARK;
        seg_d      = SEG_DARK;
        blink_dark = error_doble & ~blink_fase_d;
        if (!blink_dark) begin
            case (state_d)
                SHOW0: begin
                    anodo_d = 2'b10;
                    seg_d   = ~pat0_d;
                end
                SHOW1: begin
                    anodo_d = 2'b01;
                    seg_d   = ~pat1_d;
                end
                default: begin
                    anodo_d = AN_DARK;
                    seg_d   = SEG_DARK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BLANK1;
            cnt_q        <= '0;
            pat0_q       <= '0;
            pat1_q       <= '0;
            blink_cnt_q  <= '0;
            blink_fase_q <= 1'b1;
            anodo_q      <= AN_DARK;
            seg_q        <= SEG_DARK;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pat0_q       <= pat0_d;
            pat1_q       <= pat1_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_fase_q <= blink_fase_d;
            anodo_q      <= anodo_d;
            seg_q        <= seg_d;
        end
    end

    assign anodo     = anodo_q;
    assign segmentos = seg_q;

endmodule

// File: tb/tb_module_display_scan.sv
// Scoreboard bench for module_display_scan: the stimulus pushes the expected per-cycle
// display into a queue and a negedge monitor pops and compares it.
module tb_module_display_scan;

    localparam int SCAN_DIV    = 4;
    localparam int DEAD_CYCLES = 1;
    localparam int BLINK_DIV   = 16;

    localparam logic [6:0] SEG_DARK = 7'h7F;
    localparam logic [1:0] AN_DARK  = 2'b11;
    localparam logic [1:0] AN_D0    = 2'b10;
    localparam logic [1:0] AN_D1    = 2'b01;

    localparam logic [6:0] SEG_A    = 7'b0000010;
    localparam logic [6:0] SEG_B    = 7'b1111001;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;
    localparam logic [6:0] SEG_ONE  = 7'b1111001;
    localparam logic [6:0] SEG_TWO  = 7'b0100100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] salida_mux;
    logic       error_simple;
    logic       error_doble;
    logic       no_error;
    logic [1:0] anodo;
    logic [6:0] segmentos;

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic doble_seen = 1'b0;
    bit   rand_on = 1'b0;
    int   run_len = 0;
    logic [1:0] prev_an = AN_DARK;

    module_display_scan #(
        .SCAN_DIV   (SCAN_DIV),
        .DEAD_CYCLES(DEAD_CYCLES),
        .BLINK_DIV  (BLINK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .salida_mux  (salida_mux),
        .error_simple(error_simple),
        .error_doble (error_doble),
        .no_error    (no_error),
        .anodo       (anodo),
        .segmentos   (segmentos)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [1:0] an, input logic [6:0] seg);
        checks++;
        if (anodo !== an || segmentos !== seg) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got anodo=%b seg=%b, want anodo=%b seg=%b",
                     tag, cyc, anodo, segmentos, an, seg);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output(e.tag, e.an, e.seg);
        end
    end

    // Random-phase checker: digit enables never both low, and every lit run is SCAN_DIV long.
    always @(negedge clk) begin
        if (rand_on) begin
            checks++;
            if (anodo == 2'b00) begin
                errors++;
                $display("[TB] FAIL anodo_both_low: got anodo=%b, want never 00", anodo);
            end
            if (anodo == AN_DARK) begin
                if (run_len > 0) begin
                    checks++;
                    if (run_len != SCAN_DIV) begin
                        errors++;
                        $display("[TB] FAIL show_length: got %0d cycles, want %0d", run_len, SCAN_DIV);
                    end
                end
                run_len = 0;
            end else if (run_len > 0 && anodo != prev_an) begin
                checks++;
                errors++;
                $display("[TB] FAIL show_length: got %0d cycles then digit switch with no gap, want %0d",
                         run_len, SCAN_DIV);
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_an = anodo;
        end
    end

    task automatic apply_step(input logic [1:0] an, input logic [6:0] seg, input string tag);
        exp_t e;
        e.an  = an;
        e.seg = seg;
        e.tag = tag;
        exp_q.push_back(e);
        doble_seen = error_doble;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_show(input logic [1:0] an, input logic [6:0] seg, input string tag);
        if (doble_seen && ((cyc / BLINK_DIV) % 2 == 1)) begin
            apply_step(AN_DARK, SEG_DARK, {tag, "_blink"});
        end else begin
            apply_step(an, seg, tag);
        end
    endtask

    task automatic apply_period(input logic [6:0] seg0, input logic [6:0] seg1, input string tag);
        apply_step(AN_DARK, SEG_DARK, {tag, "_blank1"});
        for (int i = 0; i < SCAN_DIV; i++) apply_show(AN_D0, seg0, {tag, "_show0"});
        apply_step(AN_DARK, SEG_DARK, {tag, "_blank0"});
        for (int i = 0; i < SCAN_DIV; i++) apply_show(AN_D1, seg1, {tag, "_show1"});
    endtask

    initial begin
        salida_mux   = 7'b1111101;
        error_simple = 1'b0;
        error_doble  = 1'b0;
        no_error     = 1'b1;
        rst          = 1'b1;

        repeat (3) @(negedge clk);
        check_output("reset_state", AN_DARK, SEG_DARK);

        @(posedge clk);
        #1;
        rst        = 1'b0;
        cyc        = 0;
        doble_seen = 1'b0;

        apply_period(SEG_A, SEG_ZERO, "basic_a");
        apply_period(SEG_A, SEG_ZERO, "basic_b");

        apply_step(AN_DARK, SEG_DARK, "hold_blank1");
        apply_show(AN_D0, SEG_A, "hold_show0");
        salida_mux = 7'b0000110;
        for (int i = 1; i < SCAN_DIV; i++) apply_show(AN_D0, SEG_A, "hold_show0");
        apply_step(AN_DARK, SEG_DARK, "hold_blank0");
        apply_show(AN_D1, SEG_ZERO, "hold_show1");
        no_error     = 1'b0;
        error_simple = 1'b1;
        for (int i = 1; i < SCAN_DIV; i++) apply_show(AN_D1, SEG_ZERO, "hold_show1");
        apply_period(SEG_B, SEG_ONE, "newval");

        error_simple = 1'b0;
        apply_period(SEG_B, SEG_DARK, "noflags");

        error_simple = 1'b1;
        error_doble  = 1'b1;
        for (int p = 0; p < 4; p++) apply_period(SEG_B, SEG_TWO, "blink");

        apply_step(AN_DARK, SEG_DARK, "resume_blank1");
        apply_show(AN_D0, SEG_B, "resume_show0");
        error_doble = 1'b0;
        for (int i = 1; i < SCAN_DIV; i++) apply_show(AN_D0, SEG_B, "resume_show0");
        apply_step(AN_DARK, SEG_DARK, "resume_blank0");
        for (int i = 0; i < SCAN_DIV; i++) apply_show(AN_D1, SEG_ONE, "resume_show1");

        apply_step(AN_DARK, SEG_DARK, "pre_rst_blank1");
        for (int i = 0; i < SCAN_DIV; i++) apply_show(AN_D0, SEG_B, "pre_rst_show0");
        apply_step(AN_DARK, SEG_DARK, "pre_rst_blank0");
        apply_show(AN_D1, SEG_ONE, "pre_rst_show1");
        #2;
        rst = 1'b1;
        #1;
        check_output("async_reset_dark", AN_DARK, SEG_DARK);
        @(negedge clk);
        check_output("reset_hold_dark", AN_DARK, SEG_DARK);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        cyc        = 0;
        doble_seen = 1'b0;
        apply_period(SEG_B, SEG_ONE, "restart");

        run_len = 0;
        prev_an = AN_DARK;
        rand_on = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            salida_mux   = 7'($urandom());
            error_simple = 1'($urandom_range(0, 1));
            no_error     = 1'($urandom_range(0, 1));
            error_doble  = 1'b0;
            @(posedge clk);
            #1;
        end
        rand_on = 1'b0;

        for (int w = 0; w < 50 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/module_display_scan.md
MODULE_DISPLAY_SCAN -- requirements
Module: module_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 27000, clk cycles each digit is lit (1 kHz per digit at 27 MHz); legal range >= 2.
REQ-002 SHALL have parameter DEAD_CYCLES, default 270, clk cycles all digits are dark between digits; legal range >= 1.
REQ-003 SHALL have parameter BLINK_DIV, default 6750000, clk cycles per blink half-period; legal range >= 2.
REQ-004 SHALL have port clk, input, 1 bit, the single clock.
REQ-005 SHALL have port rst, input, 1 bit, reset: asynchronous, active-high.
REQ-006 SHALL have port salida_mux, input, 7 bits, digit-0 pattern {g,f,e,d,c,b,a}, bit=1 means segment lit.
REQ-007 SHALL have port error_simple, input, 1 bit, single-bit error corrected flag.
REQ-008 SHALL have port error_doble, input, 1 bit, uncorrectable double-error flag.
REQ-009 SHALL have port no_error, input, 1 bit, clean-word flag.
REQ-010 SHALL have port anodo, output, 2 bits, active-low digit enables; bit0 = digit 0, bit1 = digit 1.
REQ-011 SHALL have port segmentos, output, 7 bits, active-low segment drive {g..a}.

Function
REQ-012 SHALL implement a four-state FSM: SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0.
REQ-013 Each SHOW state SHALL last exactly SCAN_DIV cycles, and each BLANK state exactly DEAD_CYCLES cycles, using one shared down/up counter cleared on every state change.
REQ-014 In a BLANK state, anodo SHALL be 2'b11 and segmentos 7'h7F.
REQ-015 In SHOW0, anodo SHALL be 2'b10 and segmentos ~pat0; in SHOW1, anodo SHALL be 2'b01 and segmentos ~pat1.
REQ-016 anodo and segmentos SHALL be registered, changing only on the clk edge that changes state (no combinational path from inputs).
REQ-017 pat0 SHALL be captured from salida_mux on the edge entering SHOW0 and held constant for the whole SHOW0.
REQ-018 pat1 SHALL be captured on the edge entering SHOW1, using this priority:
  - error_doble: 7'b1011011 ("2")
  - else error_simple: 7'b0000110 ("1")
  - else no_error: 7'b0111111 ("0")
  - else: 7'b0000000 (blank)
REQ-019 A free-running blink counter SHALL wrap every BLINK_DIV cycles and toggle blink_fase on each wrap; it is independent of the FSM.
REQ-020 While error_doble (sampled each cycle) is 1 and blink_fase is 0, a SHOW state SHALL output segmentos 7'h7F and anodo 2'b11, while the FSM keeps sequencing.
REQ-021 When error_doble falls, blinking SHALL stop on the next edge, and normal output SHALL resume within the current SHOW state.
REQ-022 Input changes during a SHOW state SHALL NOT alter the segments until the next capture.
REQ-023 Both bits of anodo SHALL never be 0 simultaneously, in any cycle.

Reset
REQ-024 While rst = 1, the following SHALL hold asynchronously:
  - state = BLANK1, scan counter = 0, blink counter = 0, blink_fase = 1
  - pat0 = pat1 = 0
  - anodo = 2'b11, segmentos = 7'h7F
REQ-025 After rst falls, the FSM SHALL spend DEAD_CYCLES cycles in BLANK1, then enter SHOW0 with salida_mux captured.
REQ-026 rst asserted mid-SHOW SHALL force dark outputs in the same cycle, with no clk edge required.

Verification (SCAN_DIV=4, DEAD_CYCLES=1, BLINK_DIV=16)
REQ-027 Release reset with salida_mux=7'b1111101 and no_error=1. Required response:
  - 1 cycle dark
  - 4 cycles anodo=10, segmentos=7'b0000010
  - 1 cycle dark
  - 4 cycles anodo=01, segmentos=7'b1000000
  - period repeats every 10 cycles
REQ-028 Change salida_mux mid-SHOW0. Required response: segmentos unchanged until the next SHOW0, which shows the new value.
REQ-029 Hold error_simple=1 with error_doble=1. Required response: the digit-1 pattern is "2" (segmentos=7'b0100100), and digits are dark for 16-cycle windows alternating with 16 lit cycles.
REQ-030 Drive all flags 0. Required response: SHOW1 gives anodo=01, segmentos=7'h7F.
REQ-031 Pulse rst asynchronously between clk edges during SHOW1. Required response: outputs go dark immediately, and the sequence restarts per REQ-025.
REQ-032 Over 10,000 random-stimulus cycles, assert REQ-023 and check that each SHOW length is exactly 4 cycles.
